learn_judge: RTL and testbench
==============================

Name: learn_judge

Overview:
- Parametrised learning-mode judge. Steps through a song ROM, prompts the expected note, grades each player keypress on timing and correctness, and accumulates a score.
- Generalises the first-generation learning player:
  - configurable key count, note width and song depth
  - programmable grade windows
  - a timeout/miss path
  - explicit rest and end-of-song handling
  - saturating score with best-score retention
  - start/restart control
- Sits between the key debouncer and the song ROM. Drives the prompt LEDs, the buzzer enable and the score display encoder.

Parameters:
- KEY_N, 7, number of note keys; key i maps to note i+1.
- NOTE_W, 4, note code width; 0 = rest, all-ones = end-of-song.
- ADDR_W, 5, song ROM address width.
- SCORE_W, 10, score width; saturates at 2^SCORE_W-1.
- TICK_DIV, 100000, clk cycles per judge tick.
- WIN_S, 10, ticks; press with elapsed < WIN_S earns grade S.
- WIN_A, 20, ticks; elapsed < WIN_A earns grade A.
- WIN_B, 30, ticks; elapsed < WIN_B earns grade B; otherwise grade C.
- TIMEOUT, 60, ticks without a press before a miss is declared.
- REST_TICKS, 8, ticks spent on a rest note.
- HOLD_MAX, 40, maximum ticks in HOLD before a forced advance.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begin or restart the song from address 0
- key_in  in  KEY_N  debounced key levels, 1 = pressed
- rom_addr  out  ADDR_W  song ROM address
- rom_note  in  NOTE_W  ROM data, valid one cycle after rom_addr changes
- prompt_note  out  NOTE_W  note currently expected; 0 when not in PROMPT/HOLD
- tone_en  out  1  buzzer enable; high only while a correct key is held
- grade  out  2  last grade: 3=S, 2=A, 1=B, 0=C/miss
- grade_vld  out  1  one-cycle pulse when a note is judged
- score  out  SCORE_W  running score
- best_score  out  SCORE_W  highest completed-song score
- miss_cnt  out  ADDR_W  wrong presses plus timeouts in the current run
- busy  out  1  high from start until DONE
- done  out  1  level, high in DONE

Behaviour:
- Reset values:
  - all outputs 0; FSM in IDLE
  - tick prescaler and elapsed counter cleared
  - best_score cleared
- Tick generation: a tick is a one-cycle strobe every TICK_DIV clk cycles. The prescaler free-runs and is cleared on reset and on start.
- FSM states: IDLE, FETCH, PROMPT, HOLD, DONE.
- IDLE: start -> FETCH. Entering FETCH from IDLE or DONE, or via restart, does all of:
  - rom_addr := 0
  - score := 0
  - miss_cnt := 0
  - elapsed := 0
- FETCH: exactly 1 cycle (ROM latency). Then:
  - rom_note = all-ones -> DONE
  - otherwise -> PROMPT; prompt_note := rom_note; elapsed := 0
- PROMPT, rest note (prompt_note = 0):
  - ignore keys
  - when elapsed reaches REST_TICKS, advance
- PROMPT, non-rest note:
  - elapsed increments per tick and saturates.
  - A press event is key_in changing from all-zero to non-zero on a clk edge.
  - Correct press: key_in is one-hot with index+1 = prompt_note.
    - grade from elapsed: S/A/B/C per the windows
    - score += 4/3/2/1, saturating
    - grade_vld pulses
    - -> HOLD with tone_en = 1
  - Wrong or multi-key press:
    - grade := 0; grade_vld pulses; miss_cnt += 1
    - -> HOLD with tone_en = 0
  - No press and elapsed reaches TIMEOUT:
    - grade := 0; grade_vld pulses; miss_cnt += 1
    - advance
- HOLD:
  - elapsed restarts at 0
  - tone_en stays at its entry value while any key remains held
  - key_in all-zero, or elapsed reaches HOLD_MAX -> tone_en := 0; advance
- Advance:
  - rom_addr = 2^ADDR_W-1 -> DONE (wrap treated as end)
  - otherwise rom_addr += 1 -> FETCH
- DONE:
  - on entry: done := 1, busy := 0; if score > best_score then best_score := score
  - stays in DONE; start -> FETCH (best kept)
- Simultaneous events:
  - start in any state restarts immediately and has priority over a press or timeout in the same cycle. The restart clears tone_en and produces no grade_vld.
  - A press in the same cycle as a timeout is judged as a press.
- A key already held when PROMPT is entered is not a press event; the player must release first.
- Reset mid-operation returns to IDLE and clears best_score.
- miss_cnt saturates at 2^ADDR_W-1.

Decomposition:
- Shared package learn_pkg:
  - state enum
  - grade codes
  - points constants PTS_S=4, PTS_A=3, PTS_B=2, PTS_C=1
  - NOTE_REST=0
  - NOTE_END = all-ones function of NOTE_W
- One sub-module: tick_prescaler, parameter DIV, outputs the tick strobe, with a synchronous clear input.

Test Plan:
Bench settings: TICK_DIV=4, WIN_S=2, WIN_A=4, WIN_B=6, TIMEOUT=10, REST_TICKS=3, HOLD_MAX=5; ROM = [3,0,5,F].
- Reset, then start; press key 2 (note 3) 1 tick after prompt; release -> grade=3, score=4, tone_en high during hold, rom_addr 0->1.
- Rest at address 1 -> rest lasts 3 ticks, no grade_vld, keys ignored; then prompt_note=5.
- At note 5, press key 0 -> grade_vld with grade=0, miss_cnt=1, tone_en stays 0. Then end marker -> done=1, best_score=4.
- Restart, then press nothing at every note -> 2 timeouts at 10 ticks each, score=0, miss_cnt=2, best_score stays 4.
- Hold the correct key for over 5 ticks -> forced advance after HOLD_MAX; held key not re-judged at next prompt until released.
- Start asserted mid-HOLD -> rom_addr=0, score=0, tone_en=0 next cycle, no grade_vld. Reset mid-song -> all outputs 0, best_score=0.

Source files
------------

// File: rtl/learn_pkg.sv
// rtl/learn_pkg.sv - shared states, grade codes and point values for the learning-mode judge
package learn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_PROMPT,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam logic [1:0] GRADE_S = 2'd3;
   localparam logic [1:0] GRADE_A = 2'd2;
   localparam logic [1:0] GRADE_B = 2'd1;
   localparam logic [1:0] GRADE_C = 2'd0;

   localparam logic [2:0] PTS_S = 3'd4;
   localparam logic [2:0] PTS_A = 3'd3;
   localparam logic [2:0] PTS_B = 3'd2;
   localparam logic [2:0] PTS_C = 3'd1;

   localparam int NOTE_REST = 0;

   // End-of-song marker is the all-ones note code.
   function automatic int note_end(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/learn_judge_tick_prescaler.sv
// rtl/learn_judge_tick_prescaler.sv - free-running divider emitting a one-cycle tick every DIV clocks
module tick_prescaler #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/learn_judge.sv
// rtl/learn_judge.sv - learning-mode judge: walks the song ROM, grades keypresses, keeps score
module learn_judge
   import learn_pkg::*;
#(
   parameter int KEY_N      = 7,
   parameter int NOTE_W     = 4,
   parameter int ADDR_W     = 5,
   parameter int SCORE_W    = 10,
   parameter int TICK_DIV   = 100000,
   parameter int WIN_S      = 10,
   parameter int WIN_A      = 20,
   parameter int WIN_B      = 30,
   parameter int TIMEOUT    = 60,
   parameter int REST_TICKS = 8,
   parameter int HOLD_MAX   = 40
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [KEY_N-1:0]   key_in,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [NOTE_W-1:0]  rom_note,
   output logic [NOTE_W-1:0]  prompt_note,
   output logic               tone_en,
   output logic [1:0]         grade,
   output logic               grade_vld,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] best_score,
   output logic [ADDR_W-1:0]  miss_cnt,
   output logic               busy,
   output logic               done
);

   localparam int EL_M0  = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
   localparam int EL_M1  = (EL_M0 > REST_TICKS) ? EL_M0 : REST_TICKS;
   localparam int EL_MAX = (EL_M1 > WIN_B) ? EL_M1 : WIN_B;
   localparam int EL_W   = $clog2(EL_MAX + 1);
   localparam logic [NOTE_W-1:0] NOTE_END = NOTE_W'(note_end(NOTE_W));

   state_t               r_state, w_state_n;
   logic [ADDR_W-1:0]    r_addr, w_addr_n;
   logic [NOTE_W-1:0]    r_note, w_note_n;
   logic [EL_W-1:0]      r_elapsed, w_elapsed_n;
   logic [SCORE_W-1:0]   r_score, w_score_n;
   logic [SCORE_W-1:0]   r_best, w_best_n;
   logic [ADDR_W-1:0]    r_miss, w_miss_n;
   logic                 r_tone, w_tone_n;
   logic [1:0]           r_grade, w_grade_n;
   logic                 r_gvld, w_gvld_n;
   logic [KEY_N-1:0]     r_key_prev;

   logic                 w_tick;
   logic                 w_press;
   logic                 w_correct;
   logic [KEY_N-1:0]     w_want;
   logic [EL_W-1:0]      w_el_inc;
   logic [1:0]           w_pgrade;
   logic [2:0]           w_pts;
   logic [SCORE_W:0]     w_sum;
   logic [SCORE_W-1:0]   w_score_sat;
   logic [ADDR_W-1:0]    w_miss_inc;
   logic                 w_adv;
   logic                 w_to_done;

   tick_prescaler #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (start),
      .o_tick (w_tick)
   );

   // A press is only the all-released to something-pressed transition, so held keys never re-trigger.
   assign w_press   = (r_key_prev == '0) && (key_in != '0);
   assign w_want    = ((r_note != '0) && (32'(r_note) <= KEY_N))
                      ? (KEY_N'(1) << (r_note - NOTE_W'(1))) : '0;
   assign w_correct = (w_want != '0) && (key_in == w_want);
   assign w_el_inc  = (w_tick && (r_elapsed != '1)) ? r_elapsed + EL_W'(1) : r_elapsed;

   always_comb begin
      if (r_elapsed < EL_W'(WIN_S)) begin
         w_pgrade = GRADE_S;
         w_pts    = PTS_S;
      end else if (r_elapsed < EL_W'(WIN_A)) begin
         w_pgrade = GRADE_A;
         w_pts    = PTS_A;
      end else if (r_elapsed < EL_W'(WIN_B)) begin
         w_pgrade = GRADE_B;
         w_pts    = PTS_B;
      end else begin
         w_pgrade = GRADE_C;
         w_pts    = PTS_C;
      end
   end

   assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(w_pts);
   assign w_score_sat = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
   assign w_miss_inc  = (r_miss == '1) ? r_miss : r_miss + ADDR_W'(1);

   always_comb begin
      w_state_n   = r_state;
      w_addr_n    = r_addr;
      w_note_n    = r_note;
      w_elapsed_n = r_elapsed;
      w_score_n   = r_score;
      w_best_n    = r_best;
      w_miss_n    = r_miss;
      w_tone_n    = r_tone;
      w_grade_n   = r_grade;
      w_gvld_n    = 1'b0;
      w_adv       = 1'b0;
      w_to_done   = 1'b0;

      if (start) begin
         w_state_n   = ST_FETCH;
         w_addr_n    = '0;
         w_score_n   = '0;
         w_miss_n    = '0;
         w_elapsed_n = '0;
         w_tone_n    = 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
            end
            ST_FETCH: begin
               if (rom_note == NOTE_END) begin
                  w_to_done = 1'b1;
               end else begin
                  w_state_n   = ST_PROMPT;
                  w_note_n    = rom_note;
                  w_elapsed_n = '0;
               end
            end
            ST_PROMPT: begin
               w_elapsed_n = w_el_inc;
               if (r_note == NOTE_W'(NOTE_REST)) begin
                  if (r_elapsed >= EL_W'(REST_TICKS)) w_adv = 1'b1;
               end else if (w_press) begin
                  w_gvld_n    = 1'b1;
                  w_state_n   = ST_HOLD;
                  w_elapsed_n = '0;
                  if (w_correct) begin
                     w_grade_n = w_pgrade;
                     w_score_n = w_score_sat;
                     w_tone_n  = 1'b1;
                  end else begin
                     w_grade_n = GRADE_C;
                     w_miss_n  = w_miss_inc;
                     w_tone_n  = 1'b0;
                  end
               end else if (r_elapsed >= EL_W'(TIMEOUT)) begin
                  w_gvld_n  = 1'b1;
                  w_grade_n = GRADE_C;
                  w_miss_n  = w_miss_inc;
                  w_adv     = 1'b1;
               end
            end
            ST_HOLD: begin
               w_elapsed_n = w_el_inc;
               if ((key_in == '0) || (r_elapsed >= EL_W'(HOLD_MAX))) begin
                  w_tone_n = 1'b0;
                  w_adv    = 1'b1;
               end
            end
            ST_DONE: begin
            end
            default: begin
               w_state_n = ST_IDLE;
            end
         endcase

         // The top address is treated as the end of the song rather than wrapping.
         if (w_adv) begin
            if (r_addr == '1) begin
               w_to_done = 1'b1;
            end else begin
               w_addr_n  = r_addr + ADDR_W'(1);
               w_state_n = ST_FETCH;
            end
         end

         if (w_to_done) begin
            w_state_n = ST_DONE;
            if (r_score > r_best) w_best_n = r_score;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_note     <= '0;
         r_elapsed  <= '0;
         r_score    <= '0;
         r_best     <= '0;
         r_miss     <= '0;
         r_tone     <= 1'b0;
         r_grade    <= '0;
         r_gvld     <= 1'b0;
         r_key_prev <= '0;
      end else begin
         r_state    <= w_state_n;
         r_addr     <= w_addr_n;
         r_note     <= w_note_n;
         r_elapsed  <= w_elapsed_n;
         r_score    <= w_score_n;
         r_best     <= w_best_n;
         r_miss     <= w_miss_n;
         r_tone     <= w_tone_n;
         r_grade    <= w_grade_n;
         r_gvld     <= w_gvld_n;
         r_key_prev <= key_in;
      end
   end

   assign rom_addr    = r_addr;
   assign prompt_note = ((r_state == ST_PROMPT) || (r_state == ST_HOLD)) ? r_note : '0;
   assign tone_en     = r_tone;
   assign grade       = r_grade;
   assign grade_vld   = r_gvld;
   assign score       = r_score;
   assign best_score  = r_best;
   assign miss_cnt    = r_miss;
   assign busy        = (r_state == ST_FETCH) || (r_state == ST_PROMPT) || (r_state == ST_HOLD);
   assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_learn_judge.sv
// tb/tb_learn_judge.sv - self-checking bench for learn_judge with a grade scoreboard
module tb_learn_judge;

   localparam int KEY_N   = 7;
   localparam int NOTE_W  = 4;
   localparam int ADDR_W  = 5;
   localparam int SCORE_W = 10;

   localparam logic [KEY_N-1:0] K0 = 7'b0000001;
   localparam logic [KEY_N-1:0] K2 = 7'b0000100;
   localparam logic [KEY_N-1:0] K4 = 7'b0010000;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [KEY_N-1:0]   key_in = '0;
   logic [ADDR_W-1:0]  rom_addr;
   logic [NOTE_W-1:0]  rom_note;
   logic [NOTE_W-1:0]  prompt_note;
   logic               tone_en;
   logic [1:0]         grade;
   logic               grade_vld;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] best_score;
   logic [ADDR_W-1:0]  miss_cnt;
   logic               busy;
   logic               done;

   logic [NOTE_W-1:0] rom [0:31];
   assign rom_note = rom[rom_addr];

   always #5 clk = ~clk;

   learn_judge #(
      .KEY_N(KEY_N), .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .SCORE_W(SCORE_W),
      .TICK_DIV(4), .WIN_S(2), .WIN_A(4), .WIN_B(6),
      .TIMEOUT(10), .REST_TICKS(3), .HOLD_MAX(5)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .key_in(key_in),
      .rom_addr(rom_addr), .rom_note(rom_note), .prompt_note(prompt_note),
      .tone_en(tone_en), .grade(grade), .grade_vld(grade_vld), .score(score),
      .best_score(best_score), .miss_cnt(miss_cnt), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [1:0]         g;
      logic [SCORE_W-1:0] sc;
      logic [ADDR_W-1:0]  ms;
   } exp_t;

   typedef struct {
      int                 n;
      logic [KEY_N-1:0]   keys;
      logic [1:0]         g;
      logic [SCORE_W-1:0] sc;
      logic [ADDR_W-1:0]  ms;
      logic               tone;
   } vec_t;

   exp_t sb[$];
   vec_t vt[10];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (grade_vld) begin
         if (sb.size() == 0) begin
            check("grade_vld_unexpected", 64'(grade_vld), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_grade", 64'(grade), 64'(e.g));
            check("sb_score", 64'(score), 64'(e.sc));
            check("sb_miss", 64'(miss_cnt), 64'(e.ms));
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int lim, input string name);
      int k = 0;
      while (!done && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(name, 64'(done), 64'd1);
   endtask

   task automatic wait_note(input logic [NOTE_W-1:0] n, input int lim, input string name);
      int k = 0;
      while (prompt_note != n && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(name, 64'(prompt_note), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int cnt;
      int lim;

      for (int i = 0; i < 32; i++) rom[i] = 4'hF;
      rom[0] = 4'd3; rom[1] = 4'd0; rom[2] = 4'd5; rom[3] = 4'hF;

      vt[0] = '{1,  K2,      2'd3, 10'd4, 5'd0, 1'b1};
      vt[1] = '{7,  K2,      2'd3, 10'd4, 5'd0, 1'b1};
      vt[2] = '{8,  K2,      2'd2, 10'd3, 5'd0, 1'b1};
      vt[3] = '{15, K2,      2'd2, 10'd3, 5'd0, 1'b1};
      vt[4] = '{16, K2,      2'd1, 10'd2, 5'd0, 1'b1};
      vt[5] = '{23, K2,      2'd1, 10'd2, 5'd0, 1'b1};
      vt[6] = '{24, K2,      2'd0, 10'd1, 5'd0, 1'b1};
      vt[7] = '{40, K2,      2'd0, 10'd1, 5'd0, 1'b1};
      vt[8] = '{3,  K0,      2'd0, 10'd0, 5'd1, 1'b0};
      vt[9] = '{3,  K2 | K0, 2'd0, 10'd0, 5'd1, 1'b0};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'({rom_addr, prompt_note, tone_en, grade, grade_vld, score,
                                  best_score, miss_cnt, busy, done}), 64'd0);

      // First song: S press, rest with ignored key, wrong key, end marker.
      pulse_start();
      repeat (4) @(negedge clk);
      check("a_prompt", 64'(prompt_note), 64'd3);
      check("a_busy", 64'(busy), 64'd1);
      key_in = K2;
      sb.push_back(exp_t'{2'd3, 10'd4, 5'd0});
      @(negedge clk);
      check("a_tone_hold", 64'(tone_en), 64'd1);
      key_in = '0;
      @(negedge clk);
      check("a_addr_adv", 64'(rom_addr), 64'd1);
      check("a_tone_off", 64'(tone_en), 64'd0);
      cnt = 0;
      lim = 0;
      while (prompt_note != 4'd5 && lim < 100) begin
         if (rom_addr == 5'd1) cnt++;
         if (cnt == 3) key_in = K0;
         if (cnt == 5) key_in = '0;
         @(negedge clk);
         lim++;
      end
      check("a_rest_len", 64'(cnt), 64'd11);
      check("a_note5", 64'(prompt_note), 64'd5);
      key_in = K0;
      sb.push_back(exp_t'{2'd0, 10'd4, 5'd1});
      @(negedge clk);
      check("a_wrong_tone", 64'(tone_en), 64'd0);
      key_in = '0;
      wait_done(20, "a_done");
      check("a_busy_done", 64'(busy), 64'd0);
      check("a_best", 64'(best_score), 64'd4);
      check("a_score", 64'(score), 64'd4);
      check("a_miss", 64'(miss_cnt), 64'd1);

      // Second song: no presses at all, two timeouts.
      sb.push_back(exp_t'{2'd0, 10'd0, 5'd1});
      sb.push_back(exp_t'{2'd0, 10'd0, 5'd2});
      pulse_start();
      cnt = 0;
      while (rom_addr == 5'd0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("b_timeout_len", 64'(cnt), 64'd41);
      wait_done(200, "b_done");
      check("b_score", 64'(score), 64'd0);
      check("b_miss", 64'(miss_cnt), 64'd2);
      check("b_best_kept", 64'(best_score), 64'd4);
      check("b_pending", 64'(sb.size()), 64'd0);

      // Grade windows and wrong/multi-key presses on the first note.
      for (int i = 0; i < 10; i++) begin
         pulse_start();
         repeat (vt[i].n) @(negedge clk);
         key_in = vt[i].keys;
         sb.push_back(exp_t'{vt[i].g, vt[i].sc, vt[i].ms});
         @(negedge clk);
         check($sformatf("vec%0d_tone", i), 64'(tone_en), 64'(vt[i].tone));
         key_in = '0;
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_pending", i), 64'(sb.size()), 64'd0);
      end

      // Held key: forced advance, then no re-judge until released.
      pulse_start();
      @(negedge clk);
      key_in = K2;
      sb.push_back(exp_t'{2'd3, 10'd4, 5'd0});
      repeat (19) @(negedge clk);
      check("c_hold_addr", 64'(rom_addr), 64'd0);
      check("c_hold_tone", 64'(tone_en), 64'd1);
      @(negedge clk);
      check("c_forced_addr", 64'(rom_addr), 64'd1);
      check("c_forced_tone", 64'(tone_en), 64'd0);
      wait_note(4'd5, 60, "c_note5");
      repeat (2) @(negedge clk);
      check("c_no_rejudge", 64'(sb.size()), 64'd0);
      key_in = '0;
      @(negedge clk);
      key_in = K4;
      sb.push_back(exp_t'{2'd3, 10'd8, 5'd0});
      @(negedge clk);
      check("c_tone_note5", 64'(tone_en), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("c_restart_addr", 64'(rom_addr), 64'd0);
      check("c_restart_score", 64'(score), 64'd0);
      check("c_restart_tone", 64'(tone_en), 64'd0);
      check("c_restart_gvld", 64'(grade_vld), 64'd0);
      key_in = '0;
      repeat (2) @(negedge clk);
      check("c_pending", 64'(sb.size()), 64'd0);

      // Reset in the middle of a song.
      pulse_start();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("d_reset_outputs", 64'({rom_addr, prompt_note, tone_en, grade, grade_vld, score,
                                    best_score, miss_cnt, busy, done}), 64'd0);
      check("d_best_cleared", 64'(best_score), 64'd0);
      check("final_pending", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
